// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin arbiter sharing one combinational ALU between requesters
module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int WIDTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]     req_sel,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [1:0]               alu_sel,
    input  logic [WIDTH-1:0]         alu_out,
    input  logic [4:0]               alu_flags,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_out,
    output logic [4:0]               resp_flags,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [1:0]        alu_sel_q, alu_sel_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic [WIDTH-1:0]  resp_out_q, resp_out_d;
    logic [4:0]        resp_flags_q, resp_flags_d;
    logic              resp_valid_q, resp_valid_d;

    logic              found;
    logic [ID_W-1:0]   winner;
    logic [ID_W:0]     cand;
    logic [WIDTH-1:0]  win_a, win_b;
    logic [1:0]        win_sel;

    // Scan starts one past the last grant and wraps, so every requester is reached within NUM_REQ steps.
    always_comb begin
        found  = 1'b0;
        winner = last_grant_q;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant_q} + (ID_W+1)'(k);
            if (cand >= NREQ) cand = cand - NREQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_valid[i] && cand == (ID_W+1)'(i)) begin
                    found  = 1'b1;
                    winner = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        win_a   = '0;
        win_b   = '0;
        win_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_a   = req_a[i*WIDTH +: WIDTH];
                win_b   = req_b[i*WIDTH +: WIDTH];
                win_sel = req_sel[i*2 +: 2];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = rst_n && (state_q == IDLE) && found && (winner == ID_W'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        resp_id_d    = resp_id_q;
        resp_out_d   = resp_out_q;
        resp_flags_d = resp_flags_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    alu_a_d      = win_a;
                    alu_b_d      = win_b;
                    alu_sel_d    = win_sel;
                    resp_id_d    = winner;
                    last_grant_d = winner;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                resp_out_d   = alu_out;
                resp_flags_d = alu_flags;
                resp_valid_d = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ-1);
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            resp_id_q    <= '0;
            resp_out_q   <= '0;
            resp_flags_q <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            resp_id_q    <= resp_id_d;
            resp_out_q   <= resp_out_d;
            resp_flags_q <= resp_flags_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign resp_id    = resp_id_q;
    assign resp_out   = resp_out_q;
    assign resp_flags = resp_flags_q;
    assign resp_valid = resp_valid_q;
    assign busy       = (state_q != IDLE);

endmodule
